// File: rtl/sqrt_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sqrt_rr_arbiter
//  Purpose  : Round-robin arbiter/sequencer sharing one iterative square-root
//             engine among N_REQ requesters; ID-tagged valid/ready response.
//             Define SQRT_ARB_TIMEOUT_EN to enable the engine watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module sqrt_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_rad,
    output logic                     eng_start,
    output logic [WIDTH-1:0]         eng_rad,
    input  logic                     eng_done,
    input  logic [WIDTH-1:0]         eng_root,
    input  logic [WIDTH-1:0]         eng_rem,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_root,
    output logic [WIDTH-1:0]         rsp_rem,
    output logic                     rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [ID_W-1:0] c_last_id = ID_W'(N_REQ - 1);

    state_t             r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic               r_eng_start;
    logic [WIDTH-1:0]   r_eng_rad;
    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_root;
    logic [WIDTH-1:0]   r_rsp_rem;

    logic               w_found;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [ID_W-1:0]    w_next_ptr;
    logic [WIDTH-1:0]   w_gnt_rad;
    logic               w_accept;

`ifdef SQRT_ARB_TIMEOUT_EN
    localparam int                c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT - 1);
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_rsp_err;
    assign rsp_err = r_rsp_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign rsp_err          = 1'b0;
`endif

    // Search upward from the round-robin pointer, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        w_found   = 1'b0;
        w_gnt_idx = '0;
        idx       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(r_rr_ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!w_found && req_valid[idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = idx[ID_W-1:0];
            end
        end
    end

    assign w_gnt_rad  = req_rad[int'(w_gnt_idx)*WIDTH +: WIDTH];
    assign w_next_ptr = (w_gnt_idx == c_last_id) ? '0 : w_gnt_idx + 1'b1;
    assign w_accept   = (r_state == S_IDLE) && w_found;
    // Gated by reset so the accept strobe is silent while the block is held in reset.
    assign req_ready  = (w_accept && reset) ? (N_REQ'(1) << w_gnt_idx) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_eng_start <= 1'b0;
            r_eng_rad   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_root  <= '0;
            r_rsp_rem   <= '0;
`ifdef SQRT_ARB_TIMEOUT_EN
            r_cnt       <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_eng_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_eng_rad   <= w_gnt_rad;
                        r_rsp_id    <= w_gnt_idx;
                        r_rr_ptr    <= w_next_ptr;
                        r_eng_start <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef SQRT_ARB_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng_done) begin
                        r_rsp_root  <= eng_root;
                        r_rsp_rem   <= eng_rem;
                        r_rsp_valid <= 1'b1;
`ifdef SQRT_ARB_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
`endif
                        r_state     <= S_RESP;
                    end
`ifdef SQRT_ARB_TIMEOUT_EN
                    else if (r_cnt == c_limit) begin
                        r_rsp_root  <= '0;
                        r_rsp_rem   <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign eng_start = r_eng_start;
    assign eng_rad   = r_eng_rad;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_root  = r_rsp_root;
    assign rsp_rem   = r_rsp_rem;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sqrt_rr_arbiter
//  Purpose  : Self-checking bench for sqrt_rr_arbiter with a behavioural
//             square-root engine and a round-robin reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sqrt_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_rad = '0;
    logic           eng_start;
    logic [W-1:0]   eng_rad;
    logic           eng_done;
    logic [W-1:0]   eng_root = '0;
    logic [W-1:0]   eng_rem = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [IW-1:0]  rsp_id;
    logic [W-1:0]   rsp_root;
    logic [W-1:0]   rsp_rem;
    logic           rsp_err;

    logic eng_done_m = 1'b0;
    logic eng_inject = 1'b0;
    assign eng_done = eng_done_m | eng_inject;

    int n_checks = 0;
    int n_fail   = 0;
    int model_ptr = 0;
    int eng_lat = 4;
    bit eng_hang = 0;
    bit hold_req [N];

    always #5 clk = ~clk;

    sqrt_rr_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rad(req_rad),
        .eng_start(eng_start), .eng_rad(eng_rad), .eng_done(eng_done),
        .eng_root(eng_root), .eng_rem(eng_rem),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_root(rsp_root), .rsp_rem(rsp_rem), .rsp_err(rsp_err)
    );

    function automatic logic [W-1:0] isqrt(input logic [W-1:0] x);
        longint lo = 0;
        longint hi = 65536;
        longint mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= longint'({32'd0, x})) lo = mid;
            else hi = mid;
        end
        return lo[W-1:0];
    endfunction

    function automatic int exp_grant(input logic [N-1:0] v, input int ptr);
        for (int i = 0; i < N; i++)
            if (v[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    // Behavioural engine: done exactly eng_lat cycles after the start cycle.
    int           e_cnt = 0;
    bit           e_busy = 0;
    logic [W-1:0] e_rad = '0;
    always begin
        @(posedge clk);
        #1;
        eng_done_m = 1'b0;
        if (!reset) begin
            e_busy = 0;
        end else begin
            if (e_busy) begin
                e_cnt--;
                if (e_cnt == 0) begin
                    eng_done_m = 1'b1;
                    eng_root   = isqrt(e_rad);
                    eng_rem    = e_rad - isqrt(e_rad) * isqrt(e_rad);
                    e_busy     = 0;
                end
            end
            if (eng_start && !eng_hang) begin
                e_busy = 1;
                e_cnt  = eng_lat;
                e_rad  = eng_rad;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        model_ptr = 0;
    endtask

    // Entered just after a clock edge in an IDLE cycle with inputs set.
    task automatic serve(input int bp, output int g);
        logic [W-1:0]  rad, er, em;
        logic [IW-1:0] gid;
        int lat;
        bit bad;
        lat = eng_lat;
        g   = exp_grant(req_valid, model_ptr);
        gid = g[IW-1:0];
        @(negedge clk);
        n_checks++;
        if (req_ready !== onehot(g) || eng_start !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL grant: req_ready=%b eng_start=%b rsp_valid=%b, expected req_ready=%b start=0 valid=0",
                     req_ready, eng_start, rsp_valid, onehot(g));
        end
        if (g < 0) return;
        rad = req_rad[g*W +: W];
        er  = isqrt(rad);
        em  = rad - er * er;
        model_ptr = (g + 1) % N;
        tick();
        if (hold_req[g]) req_rad[g*W +: W] = $urandom;
        else req_valid[g] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (eng_start !== 1'b1 || eng_rad !== rad || req_ready !== '0) begin
            n_fail++;
            $display("FAIL issue: eng_start=%b eng_rad=%h req_ready=%b, expected 1 %h 0",
                     eng_start, eng_rad, req_ready, rad);
        end
        bad = 0;
        for (int k = 0; k < lat; k++) begin
            tick();
            @(negedge clk);
            if (eng_start !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== '0) bad = 1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL wait: activity seen while engine busy (lat=%0d), expected none", lat);
        end
        tick();
        rsp_ready = (bp == 0);
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== gid || rsp_root !== er || rsp_rem !== em || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL response: valid=%b id=%0d root=%h rem=%h err=%b, expected 1 %0d %h %h 0",
                     rsp_valid, rsp_id, rsp_root, rsp_rem, rsp_err, gid, er, em);
        end
        bad = 0;
        for (int i = 1; i <= bp; i++) begin
            tick();
            if (i == bp) rsp_ready = 1'b1;
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_id !== gid || rsp_root !== er || rsp_rem !== em ||
                req_ready !== '0 || eng_start !== 1'b0) bad = 1;
        end
        if (bp > 0) begin
            n_checks++;
            if (bad) begin
                n_fail++;
                $display("FAIL backpressure: response not held stable for %0d cycles", bp);
            end
        end
        tick();
    endtask

    task automatic test_reset();
        req_valid = '1;
        reset = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        n_checks++;
        if ({req_ready, eng_start, eng_rad, rsp_valid, rsp_id, rsp_root, rsp_rem, rsp_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: req_ready=%b start=%b rad=%h valid=%b id=%0d root=%h rem=%h err=%b, expected all 0",
                     req_ready, eng_start, eng_rad, rsp_valid, rsp_id, rsp_root, rsp_rem, rsp_err);
        end
        req_valid = '0;
        tick();
        reset = 1'b1;
        model_ptr = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (req_ready !== '0 || eng_start !== 1'b0) begin
                n_fail++;
                $display("FAIL idle: req_ready=%b eng_start=%b, expected 0 0", req_ready, eng_start);
            end
            tick();
        end
    endtask

    task automatic test_single();
        int g;
        eng_lat = 24;
        req_rad[1*W +: W] = 32'h0000_0019;
        req_valid = 4'b0010;
        serve(0, g);
    endtask

    task automatic test_all_four();
        int g;
        eng_lat = 6;
        req_rad = {32'h0001_0000, 32'd100, 32'd17, 32'd16};
        req_valid = '1;
        reset = 1'b0;
        tick();
        apply_reset();
        for (int i = 0; i < N; i++) serve(0, g);
    endtask

    task automatic test_fairness_wrap();
        int g;
        eng_lat = 3;
        hold_req[0] = 1;
        hold_req[3] = 1;
        req_rad[0*W +: W] = $urandom;
        req_rad[3*W +: W] = $urandom;
        req_valid = 4'b1001;
        for (int i = 0; i < 4; i++) serve(0, g);
        hold_req[0] = 0;
        hold_req[3] = 0;
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        int g;
        eng_lat = 5;
        req_rad[2*W +: W] = 32'h0009_0000;
        req_valid = 4'b0100;
        serve(10, g);
    endtask

    task automatic test_reset_mid();
        int g;
        eng_lat = 30;
        req_rad[1*W +: W] = 32'd144;
        req_valid = 4'b0010;
        @(negedge clk);
        n_checks++;
        if (req_ready !== onehot(exp_grant(req_valid, model_ptr))) begin
            n_fail++;
            $display("FAIL reset_mid_grant: req_ready=%b, expected %b", req_ready, onehot(exp_grant(req_valid, model_ptr)));
        end
        tick();
        req_valid = '0;
        repeat (5) tick();
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, eng_start, eng_rad, rsp_valid, rsp_id, rsp_root, rsp_rem, rsp_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: outputs not cleared, rad=%h id=%0d, expected all 0", eng_rad, rsp_id);
        end
        repeat (2) tick();
        req_rad = {$urandom, $urandom, $urandom, $urandom};
        req_valid = '1;
        reset = 1'b1;
        model_ptr = 0;
        eng_lat = 2;
        serve(0, g);
    endtask

    task automatic test_random();
        int g;
        logic [N-1:0] add;
        for (int r = 0; r < 40; r++) begin
            eng_lat = $urandom_range(1, 8);
            if (req_valid == '0) begin
                @(negedge clk);
                n_checks++;
                if (req_ready !== '0) begin
                    n_fail++;
                    $display("FAIL random_idle: req_ready=%b, expected 0", req_ready);
                end
                tick();
                add = N'($urandom_range(1, 15));
            end else begin
                add = N'($urandom_range(0, 15));
            end
            for (int k = 0; k < N; k++) begin
                if (add[k] && !req_valid[k]) begin
                    req_rad[k*W +: W] = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 1000);
                    hold_req[k] = $urandom_range(0, 3) == 0;
                    req_valid[k] = 1'b1;
                end
            end
            serve($urandom_range(0, 3), g);
        end
        for (int k = 0; k < N; k++) hold_req[k] = 0;
        req_valid = '0;
    endtask

`ifdef SQRT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit bad;
        eng_hang = 1;
        req_rad[2*W +: W] = 32'd49;
        req_valid = 4'b0100;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL timeout_grant: req_ready=%b, expected 0100", req_ready);
        end
        tick();
        req_valid = '0;
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            tick();
            @(negedge clk);
            if (rsp_valid !== 1'b0) bad = 1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL timeout_early: rsp_valid rose before 65 cycles, expected 0");
        end
        tick();
        rsp_ready = 1'b0;
        eng_inject = 1'b1;
        eng_root = 32'h1234;
        eng_rem = 32'h55;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_root !== '0 || rsp_rem !== '0 || rsp_id !== 2'd2) begin
            n_fail++;
            $display("FAIL timeout_rsp: valid=%b err=%b root=%h rem=%h id=%0d, expected 1 1 0 0 2",
                     rsp_valid, rsp_err, rsp_root, rsp_rem, rsp_id);
        end
        tick();
        eng_inject = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rsp_err !== 1'b1 || rsp_root !== '0 || rsp_rem !== '0) begin
            n_fail++;
            $display("FAIL timeout_late_done: err=%b root=%h rem=%h, expected 1 0 0", rsp_err, rsp_root, rsp_rem);
        end
        tick();
        eng_hang = 0;
        model_ptr = 3;
    endtask
`endif

    initial begin
        for (int k = 0; k < N; k++) hold_req[k] = 0;
        test_reset();
        test_single();
        test_all_four();
        test_fairness_wrap();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef SQRT_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sqrt_rr_arbiter.md
# sqrt_rr_arbiter

Round-robin arbiter and sequencer that shares one iterative square-root engine (Q16.16 radicand, multi-cycle, start/done handshake) among N_REQ requesters in the mean/statistics pipeline. It accepts one radicand at a time, starts the engine, waits for completion, and returns root and remainder tagged with the requester ID on a valid/ready response channel. With the optional watchdog, a hung engine cannot stall the pipeline.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 32, radicand, root and remainder width (Q16.16)
- ID_W, 2, requester ID width, equal to clog2(N_REQ)
- TIMEOUT, 64, watchdog limit in cycles (used only with SQRT_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept, one-hot or zero
- req_rad  in  N_REQ*WIDTH  radicands; requester k uses bits [k*WIDTH +: WIDTH]
- eng_start  out  1  one-cycle engine start pulse
- eng_rad  out  WIDTH  radicand to the engine
- eng_done  in  1  one-cycle engine completion pulse
- eng_root  in  WIDTH  engine root, valid while eng_done=1
- eng_rem  in  WIDTH  engine remainder, valid while eng_done=1
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  requester index of the response
- rsp_root  out  WIDTH  root
- rsp_rem  out  WIDTH  remainder
- rsp_err  out  1  timeout flag; always 0 without SQRT_ARB_TIMEOUT_EN

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: the grant goes to the first asserted req_valid, searching from rr_ptr upward and wrapping modulo N_REQ.
  - req_ready[g] is asserted combinationally for the granted index only; acceptance happens in that cycle.
  - On acceptance: latch req_rad[g] into eng_rad, latch g into rsp_id, set rr_ptr to (g+1) mod N_REQ, go to ISSUE.
  - If no req_valid is set, stay in IDLE with req_ready all 0.
- ISSUE: eng_start=1 for exactly one cycle, then go to WAIT.
- WAIT: on eng_done=1, latch eng_root and eng_rem into rsp_root and rsp_rem, clear rsp_err, go to RESP.
- RESP: hold rsp_valid=1 and stable data until rsp_ready=1, then return to IDLE.
- req_ready is 0 in every state except IDLE. Only one request is in flight; no queueing.
- eng_done is ignored outside WAIT, and it is not captured in the ISSUE cycle itself. The engine contract requires at least 1 cycle between start and done.
- Values are passed through unchanged; the arbiter does no arithmetic on data.
- rr_ptr is an ID_W-bit register. Wrap-around: after granting N_REQ-1, the search starts at 0.
- Simultaneous requests: the one nearest rr_ptr wins. Losers keep req_valid asserted and are served in later rounds; each requester waits at most N_REQ-1 grants.

## Timing
- Reset values: req_ready=0, eng_start=0, eng_rad=0, rsp_valid=0, rsp_id=0, rsp_root=0, rsp_rem=0, rsp_err=0, rr_ptr=0, state=IDLE.
- Request accepted at cycle T: eng_start at T+1.
- Engine latency L: eng_done at T+1+L, rsp_valid at T+2+L.
- With rsp_ready held high: rsp_valid is high for 1 cycle, IDLE at T+3+L, next acceptance possible in that cycle.
- Throughput: one result per L+3 cycles.
- Reset mid-operation, in any state: all outputs return to reset values asynchronously and the in-flight request is dropped. The engine shares this reset.

## Configuration
- SQRT_ARB_TIMEOUT_EN defined:
  - A cycle counter clears on ISSUE and increments in WAIT.
  - If it reaches TIMEOUT with no eng_done, go to RESP with rsp_err=1, rsp_root=0, rsp_rem=0, same rsp_id.
  - A late eng_done arriving after the timeout is ignored.
- SQRT_ARB_TIMEOUT_EN undefined: no counter; WAIT persists until eng_done; rsp_err is tied to 0.

## Test plan
- Single request: req_valid[1]=1, req_rad=0x00000019, bench engine with L=24 returns root 5, rem 0 -> req_ready[1] pulses once, eng_start 1 cycle later, rsp_valid at +26 with rsp_id=1, rsp_root=5, rsp_rem=0.
- All four requesters valid from reset with radicands 16, 17, 100, 0x00010000 -> responses in order id 0, 1, 2, 3 with roots 4, 4, 10, 0x100 and rems 0, 1, 0, 0.
- Fairness and wrap: requesters 3 and 0 held valid continuously -> grants alternate 0, 3, 0, 3; rr_ptr wraps from 3 to 0.
- Backpressure: rsp_ready=0 for 10 cycles during RESP -> rsp_valid and data stay stable, req_ready stays 0, no eng_start; the response completes when rsp_ready=1.
- Reset asserted during WAIT -> all outputs go to 0 immediately; after release the next request is granted from requester 0.
- With SQRT_ARB_TIMEOUT_EN and TIMEOUT=64, engine never asserts done -> rsp_valid 65 cycles after eng_start with rsp_err=1 and root/rem 0; a late eng_done is ignored.
